// File: rtl/ppl_frame_writer.sv
// Render pipeline sink: buffers shaded pixels in a small FIFO, writes them into the back
// framebuffer over a req/ack port, and swaps front/back buffers on each vs rising edge.
module ppl_frame_writer #(
    parameter int unsigned H_DISP     = 1280,
    parameter int unsigned V_DISP     = 720,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned PPL_SLACK  = 6,
    parameter logic [23:0] BUF0_BASE  = 24'h000000,
    parameter logic [23:0] BUF1_BASE  = 24'h100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pixel_valid,
    input  logic [19:0] pixel_addr,
    input  logic [15:0] pixel_data,
    input  logic        vs,
    output logic        next_en,
    output logic        wr_req,
    output logic [23:0] wr_addr,
    output logic [15:0] wr_data,
    input  logic        wr_ack,
    output logic        buf_sel,
    output logic        front_sel,
    output logic        frame_done,
    output logic        overflow
);
    localparam int unsigned PtrW      = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW      = PtrW + 1;
    localparam int unsigned NumPix    = H_DISP * V_DISP;
    localparam int unsigned NextEnMax = FIFO_DEPTH - 1 - PPL_SLACK;

    typedef enum logic [1:0] {StRun, StDrain, StSwap} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [35:0]     mem_q [FIFO_DEPTH];
    logic            vs_q, next_en_q, buf_sel_q, frame_done_q, overflow_q;
    logic            full, empty, push_try, push, pop, vs_rise, swap_now;
    logic [35:0]     head;
    logic [23:0]     base;

    always_comb begin
        full     = (count_q == CntW'(FIFO_DEPTH));
        empty    = (count_q == '0);
        // Addresses at or beyond the frame size are end-of-frame markers, never stored.
        push_try = pixel_valid && (32'(pixel_addr) < NumPix);
        push     = push_try && !full;
        pop      = !empty && wr_ack;
        vs_rise  = vs && !vs_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (vs_rise) state_d = StDrain;
            StDrain: if (empty) state_d = StSwap;
            StSwap:  state_d = StRun;
            default: state_d = StRun;
        endcase
        swap_now = (state_q == StDrain) && (state_d == StSwap);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {pixel_addr, pixel_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StRun;
            count_q      <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            vs_q         <= 1'b0;
            next_en_q    <= 1'b0;
            buf_sel_q    <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            vs_q         <= vs;
            next_en_q    <= (state_d == StRun) && (32'(count_d) <= NextEnMax);
            frame_done_q <= swap_now;
            if (swap_now) begin
                buf_sel_q <= ~buf_sel_q;
            end
            if (push) begin
                wptr_q <= wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            if (push_try && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Outputs derive from the count register so wr_req drops with the async reset.
    always_comb begin
        head       = mem_q[rptr_q];
        base       = buf_sel_q ? BUF1_BASE : BUF0_BASE;
        wr_req     = !empty;
        wr_addr    = wr_req ? (base + {4'h0, head[35:16]}) : 24'h0;
        wr_data    = wr_req ? head[15:0] : 16'h0;
        next_en    = next_en_q;
        buf_sel    = buf_sel_q;
        front_sel  = ~buf_sel_q;
        frame_done = frame_done_q;
        overflow   = overflow_q;
    end

endmodule

// File: tb/tb_ppl_frame_writer.sv
// Scoreboard bench for ppl_frame_writer: directed pixel streams, expected writes queued by
// the stimulus and popped by a monitor on every accepted write.
module tb_ppl_frame_writer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        pixel_valid;
    logic [19:0] pixel_addr;
    logic [15:0] pixel_data;
    logic        vs;
    logic        next_en;
    logic        wr_req;
    logic [23:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic        buf_sel;
    logic        front_sel;
    logic        frame_done;
    logic        overflow;

    always #5 clk = ~clk;

    ppl_frame_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pixel_valid(pixel_valid),
        .pixel_addr (pixel_addr),
        .pixel_data (pixel_data),
        .vs         (vs),
        .next_en    (next_en),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .buf_sel    (buf_sel),
        .front_sel  (front_sel),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t  exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   fd_count = 0;
    logic exp_buf  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (frame_done === 1'b1) fd_count++;
            if (wr_req === 1'b1 && wr_ack === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL spurious_write: got write to %h data %h, expected none",
                             wr_addr, wr_data);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(w.addr));
                    check("wr_data", 32'(wr_data), 32'(w.data));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_px(input logic [19:0] a, input logic [15:0] d, input bit exp_wr);
        wr_t w;
        pixel_valid = 1'b1;
        pixel_addr  = a;
        pixel_data  = d;
        if (exp_wr) begin
            w.addr = (exp_buf ? 24'h100000 : 24'h000000) + {4'h0, a};
            w.data = d;
            exp_q.push_back(w);
        end
        tick();
        pixel_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || wr_req) && n < 200) begin
            tick();
            n++;
        end
        check(name, 32'(n < 200), 32'd1);
    endtask

    initial begin
        int n;
        int fd0;
        rst_n = 1'b1;
        pixel_valid = 1'b0;
        pixel_addr = '0;
        pixel_data = '0;
        vs = 1'b0;
        wr_ack = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_next_en", 32'(next_en), 32'd0);
        check("rst_wr_req", 32'(wr_req), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_buf_sel", 32'(buf_sel), 32'd0);
        check("rst_front_sel", 32'(front_sel), 32'd1);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        check("first_cycle_next_en", 32'(next_en), 32'd0);
        tick();
        check("next_en_up", 32'(next_en), 32'd1);

        // Basic stream, always acked
        wr_ack = 1'b1;
        for (int i = 0; i < 4; i++) push_px(20'(i), 16'(16'h1111 * (i + 1)), 1'b1);
        wait_drain("s1_drain");
        check("s1_next_en", 32'(next_en), 32'd1);
        check("s1_no_frame_done", 32'(fd_count), 32'd0);

        // Back-pressure: pipeline obeys next_en, then emits its slack
        wr_ack = 1'b0;
        n = 0;
        while (next_en && n < 30) begin
            push_px(20'(100 + n), 16'(16'hA000 + n), 1'b1);
            n++;
        end
        check("s2_pushes_before_stall", 32'(n), 32'd10);
        for (int i = 0; i < 6; i++) push_px(20'(110 + i), 16'(16'hA00A + i), 1'b1);
        check("s2_next_en_low", 32'(next_en), 32'd0);
        check("s2_no_overflow", 32'(overflow), 32'd0);
        wr_ack = 1'b1;
        wait_drain("s2_drain");
        check("s2_next_en_back", 32'(next_en), 32'd1);

        // Overflow: 17 forced pushes into a 16-entry FIFO
        wr_ack = 1'b0;
        for (int i = 0; i < 17; i++) push_px(20'(200 + i), 16'(16'hB000 + i), i < 16);
        check("s3_overflow", 32'(overflow), 32'd1);
        wr_ack = 1'b1;
        wait_drain("s3_drain");
        check("s3_overflow_sticky", 32'(overflow), 32'd1);

        // Frame swap with 3 pending writes and slow acks
        wr_ack = 1'b0;
        for (int i = 0; i < 3; i++) push_px(20'(10 + i), 16'(16'hC000 + i), 1'b1);
        fd0 = fd_count;
        vs = 1'b1;
        tick();
        check("s4_next_en_drain", 32'(next_en), 32'd0);
        n = 0;
        while (fd_count == fd0 && n < 40) begin
            wr_ack = n[0];
            tick();
            n++;
        end
        check("s4_buf_sel", 32'(buf_sel), 32'd1);
        check("s4_front_sel", 32'(front_sel), 32'd0);
        check("s4_queue_drained", 32'(exp_q.size()), 32'd0);
        wr_ack = 1'b0;
        tick();
        tick();
        tick();
        check("s4_one_frame_done", 32'(fd_count - fd0), 32'd1);
        vs = 1'b0;
        exp_buf = 1'b1;
        wr_ack = 1'b1;
        push_px(20'd5, 16'h5555, 1'b1);
        wait_drain("s4_drain_buf1");

        // Frame-end markers are discarded
        push_px(20'd921600, 16'hDEAD, 1'b0);
        check("s5_no_req_a", 32'(wr_req), 32'd0);
        push_px(20'hFFFFF, 16'hBEEF, 1'b0);
        check("s5_no_req_b", 32'(wr_req), 32'd0);
        tick();
        check("s5_no_req_c", 32'(wr_req), 32'd0);

        // Reset in the middle of a drain
        wr_ack = 1'b0;
        push_px(20'd7, 16'h7777, 1'b0);
        push_px(20'd8, 16'h8888, 1'b0);
        vs = 1'b1;
        tick();
        tick();
        check("s6_req_before_reset", 32'(wr_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("s6_req_dropped", 32'(wr_req), 32'd0);
        check("s6_buf_sel", 32'(buf_sel), 32'd0);
        check("s6_front_sel", 32'(front_sel), 32'd1);
        check("s6_next_en", 32'(next_en), 32'd0);
        check("s6_overflow_clr", 32'(overflow), 32'd0);
        vs = 1'b0;
        exp_buf = 1'b0;
        exp_q.delete();
        fd0 = fd_count;
        tick();
        rst_n = 1'b1;
        check("s6_first_next_en", 32'(next_en), 32'd0);
        tick();
        check("s6_next_en_up", 32'(next_en), 32'd1);
        wr_ack = 1'b1;
        for (int i = 0; i < 4; i++) push_px(20'(i), 16'(16'h1111 * (i + 1)), 1'b1);
        wait_drain("s6_drain");
        check("s6_no_frame_done", 32'(fd_count - fd0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ppl_frame_writer.md
Name: ppl_frame_writer

Overview:
Consumer end of the render pipeline. It accepts shaded pixels leaving the pipeline and buffers them in a small FIFO. It drives next_en back to the pipeline controller as flow control, and writes the pixels into a double-buffered framebuffer through a req/ack memory port. On the controller's vs pulse it drains outstanding writes, swaps the front and back buffers, and signals frame completion to the display side.

Parameters:
H_DISP, 1280, horizontal resolution in pixels
V_DISP, 720, vertical resolution in pixels
FIFO_DEPTH, 16, pixel FIFO entries (power of 2)
PPL_SLACK, 6, pixels the pipeline can still emit after next_en falls (pipeline depth)
BUF0_BASE, 24'h000000, memory word address of framebuffer 0
BUF1_BASE, 24'h100000, memory word address of framebuffer 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active-low
pixel_valid  in  1  pipeline output pixel valid this cycle
pixel_addr  in  20  linear pixel index, y*H_DISP+x
pixel_data  in  16  RGB565 colour
vs  in  1  frame-complete indication from the pipeline controller (level, rising edge significant)
next_en  out  1  pipeline may advance one pixel this cycle
wr_req  out  1  memory write request
wr_addr  out  24  memory word address
wr_data  out  16  memory write data
wr_ack  in  1  memory accepted the current write
buf_sel  out  1  back buffer currently written (0 = BUF0, 1 = BUF1)
front_sel  out  1  buffer the display scans (always ~buf_sel)
frame_done  out  1  one-cycle pulse after a completed buffer swap
overflow  out  1  sticky: a pixel arrived while the FIFO was full

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, state RUN, next_en=0, wr_req=0, wr_addr=0, wr_data=0, buf_sel=0, front_sel=1, frame_done=0, overflow=0, vs edge register=0. The first cycle after reset deasserts has next_en=0; next_en follows the rule below from the second cycle.
- Push: pixel_valid=1 and pixel_addr < H_DISP*V_DISP and FIFO not full -> push {pixel_addr, pixel_data}.
  - pixel_addr >= H_DISP*V_DISP (frame-end marker) -> discarded, no push.
  - Push attempted while full -> pixel dropped, overflow set and held until reset.
- Flow control: next_en = (state==RUN) && (count <= FIFO_DEPTH-1-PPL_SLACK), registered (one-cycle latency). count is the occupancy after this cycle's push/pop.
- Memory port:
  - wr_req=1 whenever the FIFO is non-empty (including the DRAIN state), with wr_addr = base + head.addr and wr_data = head.data. wr_addr and wr_data stay stable while wr_req=1 and wr_ack=0.
  - wr_ack=1 with wr_req=1 pops the head; the next entry is presented the following cycle.
  - wr_ack while wr_req=0 is ignored.
- Base address: base = buf_sel ? BUF1_BASE : BUF0_BASE. Addition is 24-bit with zero-extended addr; wrap-around is not checked.
- Simultaneous push and pop: both take effect; count unchanged.
- FSM:
  - RUN: rising edge of vs (vs & ~vs_q) -> DRAIN. Otherwise stay.
  - DRAIN: next_en forced 0; pixels arriving from the pipeline are still pushed. FIFO empty and wr_req=0 -> SWAP.
  - SWAP (exactly 1 cycle): toggle buf_sel; front_sel follows; frame_done=1 for this cycle only -> RUN.
  - vs edges seen in DRAIN or SWAP are ignored. vs held high does not retrigger.
- Reset mid-frame: all state discarded immediately; memory writes in flight are abandoned (wr_req drops asynchronously).
- Count register is log2(FIFO_DEPTH)+1 bits; full = count==FIFO_DEPTH, empty = count==0.

Test Plan:
1. Reset then 4 pixels (addr 0..3, data 16'h1111..4444), wr_ack always 1 -> writes to 24'h000000..000003 in order with matching data; next_en=1 throughout; frame_done never pulses.
2. wr_ack held 0, pixel_valid every cycle next_en=1 -> next_en falls once count exceeds 9 (16-1-6). The pipeline's 6 slack pixels fill the FIFO to at most 16; overflow stays 0. Release wr_ack -> drains in order and next_en returns high.
3. Force 17 pushes with wr_ack=0 -> the 17th is dropped; overflow=1 and stays 1 after the FIFO drains.
4. vs rises with 3 entries queued and wr_ack=1 every other cycle -> next_en=0 during DRAIN; the 3 writes still go to BUF0 addresses. Then one frame_done pulse; buf_sel=1, front_sel=0. The next pixel at addr 5 writes to 24'h100005.
5. pixel_addr=921600 (1280*720) with pixel_valid=1 -> no push, no wr_req.
6. rst_n asserted low during DRAIN with wr_req=1 -> same-cycle wr_req=0, buf_sel=0, state RUN; after release, normal operation as in scenario 1.
